// File: rtl/verif_printf_pkg.sv
// verif_printf_pkg: shared constants, FSM state type and width helper for the binary printf formatter
package verif_printf_pkg;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_1  = 8'h31;
   localparam logic [7:0] ASCII_NL = 8'h0A;
   typedef enum logic [1:0] {IDLE, DIGIT, NL} fmt_state_t;
   function automatic int digit_cnt_w(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction
endpackage

// File: rtl/verif_sync_fifo.sv
// verif_sync_fifo: first-word-fall-through FIFO
//   clk, rst_n (async active-low) | push/din write | pop reads dout | full, empty status
module verif_sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = (AW + 1)'(1);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   // extra pointer MSB distinguishes full from empty when the index bits match
   assign empty = wr_q == rd_q;
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign dout  = mem_q[rd_q[AW-1:0]];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push && !full) wr_q <= wr_q + ONE;
         if (pop && !empty) rd_q <= rd_q + ONE;
      end
   end
   always_ff @(posedge clk) begin
      if (push && !full) mem_q[wr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/verif_printf_bin_formatter.sv
// verif_printf_bin_formatter: prints each accepted W-bit sample as ASCII binary digits (MSB first) plus newline
//   clk, reset (async active-low) | io_en, io_in_valid/ready/bits: sample input
//   io_out_valid/ready/bits: byte stream | io_busy: work pending | io_lines: completed line count
module verif_printf_bin_formatter
   import verif_printf_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         io_en,
   input  logic         io_in_valid,
   output logic         io_in_ready,
   input  logic [W-1:0] io_in_bits,
   output logic         io_out_valid,
   input  logic         io_out_ready,
   output logic [7:0]   io_out_bits,
   output logic         io_busy,
   output logic [15:0]  io_lines
);
   localparam int CW = digit_cnt_w(W);
   localparam logic [CW-1:0] LAST_DIGIT = CW'(W - 1);
   fmt_state_t     state_q, state_d;
   logic [W-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [15:0]    lines_q, lines_d;
   logic           fifo_full, fifo_empty, push, pop;
   logic [W-1:0]   fifo_dout;
   // ready depends only on FIFO occupancy, never on the output side
   assign io_in_ready  = !fifo_full;
   assign push         = io_in_valid && !fifo_full && io_en;
   assign io_out_valid = state_q != IDLE;
   assign io_out_bits  = (state_q == DIGIT) ? (shreg_q[W-1] ? ASCII_1 : ASCII_0) : ASCII_NL;
   assign io_busy      = !fifo_empty || (state_q != IDLE);
   assign io_lines     = lines_q;
   verif_sync_fifo #(.WIDTH(W), .DEPTH(DEPTH)) u_fifo (
      .clk  (clk),
      .rst_n(reset),
      .push (push),
      .pop  (pop),
      .din  (io_in_bits),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty)
   );
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      lines_d = lines_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shreg_d = fifo_dout;
               cnt_d   = LAST_DIGIT;
               state_d = DIGIT;
            end
         end
         DIGIT: begin
            if (io_out_ready) begin
               shreg_d = shreg_q << 1;
               cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
               state_d = (cnt_q == '0) ? NL : DIGIT;
            end
         end
         NL: begin
            if (io_out_ready) begin
               lines_d = lines_q + 16'd1;
               // next line starts on the same edge so lines run back-to-back
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shreg_d = fifo_dout;
                  cnt_d   = LAST_DIGIT;
                  state_d = DIGIT;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         lines_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         lines_q <= lines_d;
      end
   end
endmodule

// File: tb/tb_verif_printf_bin_formatter.sv
// tb_verif_printf_bin_formatter: scoreboard bench for the binary printf formatter
module tb_verif_printf_bin_formatter;
   localparam int W = 16;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         io_en = 1'b1;
   logic         io_in_valid = 1'b0;
   logic         io_in_ready;
   logic [W-1:0] io_in_bits = '0;
   logic         io_out_valid;
   logic         io_out_ready = 1'b1;
   logic [7:0]   io_out_bits;
   logic         io_busy;
   logic [15:0]  io_lines;
   int           n_checks = 0;
   int           n_pass = 0;
   int           hs_cnt = 0;
   logic [7:0]   exp_q[$];
   bit           stall_q = 1'b0;
   logic [7:0]   stall_bits;
   verif_printf_bin_formatter #(.W(W), .DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .io_en       (io_en),
      .io_in_valid (io_in_valid),
      .io_in_ready (io_in_ready),
      .io_in_bits  (io_in_bits),
      .io_out_valid(io_out_valid),
      .io_out_ready(io_out_ready),
      .io_out_bits (io_out_bits),
      .io_busy     (io_busy),
      .io_lines    (io_lines)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask
   // observe at negedge: handshakes seen here complete on the next rising edge
   always @(negedge clk) begin
      if (reset) begin
         if (stall_q) begin
            check("stall_valid", io_out_valid, 1);
            check("stall_bits", io_out_bits, stall_bits);
         end
         if (io_out_valid && io_out_ready) begin
            hs_cnt++;
            check("byte_set", (io_out_bits == 8'h30 || io_out_bits == 8'h31 || io_out_bits == 8'h0A), 1);
            if (exp_q.size() == 0) check("sb_extra_byte", io_out_bits, 8'hxx);
            else check("sb_byte", io_out_bits, exp_q.pop_front());
         end
         if (io_in_valid && io_in_ready && io_en) begin
            for (int b = W - 1; b >= 0; b--) exp_q.push_back(io_in_bits[b] ? 8'h31 : 8'h30);
            exp_q.push_back(8'h0A);
         end
         stall_q    = io_out_valid && !io_out_ready;
         stall_bits = io_out_bits;
      end else begin
         stall_q = 1'b0;
      end
   end
   task automatic send(input logic [W-1:0] v, input bit en);
      bit ok = 1'b0;
      io_in_bits  = v;
      io_en       = en;
      io_in_valid = 1'b1;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (io_in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      io_in_valid = 1'b0;
      io_en       = 1'b1;
   endtask
   task automatic wait_idle();
      bit ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         if (!io_busy && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", 0, 1);
   endtask
   initial begin
      logic [15:0] base_lines;
      logic [W-1:0] vals [6];
      int k, run, base_hs;
      bit acc;
      #1;
      check("rst_out_valid", io_out_valid, 0);
      check("rst_out_bits", io_out_bits, 8'h0A);
      check("rst_busy", io_busy, 0);
      check("rst_lines", io_lines, 0);
      check("rst_in_ready", io_in_ready, 1);
      #12 reset = 1'b1;
      @(posedge clk);
      #1;
      send(16'h0001, 1);
      check("t1_lat_valid0", io_out_valid, 0);
      check("t1_lat_busy", io_busy, 1);
      @(posedge clk);
      #1;
      check("t1_lat_valid1", io_out_valid, 1);
      check("t1_first_digit", io_out_bits, 8'h30);
      wait_idle();
      check("t1_lines", io_lines, 1);
      check("t1_busy", io_busy, 0);
      base_lines = io_lines;
      fork
         begin
            send(16'hFFFF, 1);
            send(16'h0000, 1);
            send(16'hA5A5, 1);
            send(16'h8000, 1);
         end
         begin
            run = 0;
            for (int i = 0; i < 50 && !io_out_valid; i++) @(negedge clk);
            while (io_out_valid && run < 300) begin
               run++;
               @(negedge clk);
            end
            check("t2_contig_bytes", run, 68);
         end
      join
      wait_idle();
      check("t2_lines", io_lines, base_lines + 16'd4);
      base_lines   = io_lines;
      vals         = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
      io_out_ready = 1'b0;
      k            = 0;
      io_in_valid  = 1'b1;
      for (int c = 0; c < 12 && k < 6; c++) begin
         io_in_bits = vals[k];
         @(negedge clk);
         acc = io_in_ready;
         @(posedge clk);
         #1;
         if (acc) k++;
      end
      io_in_valid = 1'b0;
      check("t3_accepted", k, 5);
      check("t3_in_ready", io_in_ready, 0);
      io_out_ready = 1'b1;
      wait_idle();
      check("t3_lines", io_lines, base_lines + 16'd5);
      base_lines = io_lines;
      send(16'h1234, 0);
      send(16'h0003, 1);
      wait_idle();
      check("t4_lines", io_lines, base_lines + 16'd1);
      base_lines = io_lines;
      fork
         begin
            for (int i = 0; i < 6; i++) send(W'($urandom), 1);
         end
         begin
            for (int i = 0; i < 250; i++) begin
               io_out_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      io_out_ready = 1'b1;
      wait_idle();
      check("t5_lines", io_lines, base_lines + 16'd6);
      base_hs = hs_cnt;
      send(16'hF0F0, 1);
      send(16'h1111, 1);
      for (int i = 0; i < 100 && hs_cnt < base_hs + 7; i++) begin
         @(posedge clk);
         #1;
      end
      check("t6_seven_bytes", hs_cnt, base_hs + 7);
      #1 reset = 1'b0;
      #1;
      check("t6_out_valid", io_out_valid, 0);
      check("t6_busy", io_busy, 0);
      check("t6_lines", io_lines, 0);
      check("t6_in_ready", io_in_ready, 1);
      exp_q.delete();
      @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      check("t6_post_valid", io_out_valid, 0);
      send(16'h0005, 1);
      wait_idle();
      check("t6_clean_lines", io_lines, 1);
      check("t6_sb_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
